// File: rtl/fetch_stage.sv
// fetch_stage: owns the fetch PC, issues sequential word fetches to i_cache and
// buffers {pc, instr} pairs for decode; redirects flush the buffer and drop in-flight data.
module fetch_stage #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    output logic            o_cache_valid_address,
    output logic [XLEN-1:0] o_cache_address,
    input  logic [XLEN-1:0] i_cache_data,
    input  logic            i_cache_done,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_valid,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc,
    input  logic            i_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, DISCARD = 2'd2;

    logic [1:0]      state;
    logic [XLEN-1:0] fetch_pc, req_addr, rpc, nxt_addr;
    logic [XLEN-1:0] mem_pc [FIFO_DEPTH];
    logic [XLEN-1:0] mem_instr [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count, count_after;
    logic            push, pop;

    always_comb begin
        rpc         = i_redirect_pc & ~XLEN'(3);
        nxt_addr    = req_addr + XLEN'(4);
        push        = state == WAIT && i_cache_done && !i_redirect;
        pop         = o_valid && i_ready;
        count_after = count + CW'(push) - CW'(pop);
    end

    assign o_cache_valid_address = state == WAIT || state == DISCARD;
    assign o_cache_address       = req_addr;
    assign o_valid               = count != '0;
    assign o_instr               = o_valid ? mem_instr[rd_ptr] : '0;
    assign o_pc                  = o_valid ? mem_pc[rd_ptr] : '0;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (i_redirect) begin
                        fetch_pc <= rpc;
                    end else if (count < FULL) begin
                        req_addr <= fetch_pc;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_cache_done && i_redirect) begin
                        fetch_pc <= rpc;
                        req_addr <= rpc;
                    end else if (i_cache_done) begin
                        fetch_pc <= nxt_addr;
                        if (count_after < FULL) req_addr <= nxt_addr;
                        else state <= IDLE;
                    end else if (i_redirect) begin
                        fetch_pc <= rpc;
                        state    <= DISCARD;
                    end
                end
                default: begin
                    // the address stays on the bus until the stale request completes
                    if (i_redirect) fetch_pc <= rpc;
                    if (i_cache_done) begin
                        req_addr <= i_redirect ? rpc : fetch_pc;
                        state    <= WAIT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset || i_redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count_after;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset && push) begin
            mem_pc[wr_ptr]    <= req_addr;
            mem_instr[wr_ptr] <= i_cache_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            assert (!(push && !pop && count == FULL));
            assert (!(pop && count == '0));
        end
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end of the RAPID core, directly upstream of `i_cache`. It owns the fetch PC and issues sequential word fetches to `i_cache` over its valid-address/done handshake. Returned instructions are buffered with their PCs in a small FIFO and presented to decode over a valid/ready handshake. Branch/jump redirects from the back end flush the buffer and drop any in-flight fetch.

## Interface
Parameters:
- `XLEN`, 32, address/instruction width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
- `FIFO_DEPTH`, 4, instruction buffer entries, power of two, ≥2

Ports (one clock; reset is synchronous and active-low):
- `i_clk` in 1: clock, all state updates on rising edge
- `i_reset` in 1: synchronous active-low reset
- `o_cache_valid_address` in→out 1: request to `i_cache`, held high until `i_cache_done`
- `o_cache_address` out XLEN: fetch address, stable while `o_cache_valid_address` high
- `i_cache_data` in XLEN: instruction word, valid when `i_cache_done`
- `i_cache_done` in 1: one-cycle completion pulse per request
- `i_redirect` in 1: flush and restart fetch
- `i_redirect_pc` in XLEN: new fetch PC; bits [1:0] ignored (forced 0)
- `o_valid` out 1: FIFO head valid to decode
- `o_instr` out XLEN: FIFO head instruction
- `o_pc` out XLEN: FIFO head PC
- `i_ready` in 1: decode accepts head when `o_valid && i_ready`

## Operation
- State: `fetch_pc`, `req_addr`, FIFO (`FIFO_DEPTH` × {pc, instr}, rd/wr pointers, `count` of width clog2(DEPTH)+1), FSM {IDLE, WAIT, DISCARD}.
- At most one cache request outstanding. `o_cache_valid_address` = (state==WAIT || state==DISCARD); `o_cache_address` = `req_addr`.
- Reset (`i_reset`==0 at edge): state IDLE, `fetch_pc`=RESET_PC, `req_addr`=RESET_PC, FIFO empty (pointers 0, count 0); outputs `o_valid`=0, `o_cache_valid_address`=0, `o_instr`=0, `o_pc`=0 (head entry cleared). Reset overrides all other inputs, including mid-request; the in-flight `i_cache_done` after reset is ignored (state IDLE).
- IDLE: if `i_redirect`: `fetch_pc`=redirect_pc, stay IDLE, flush. Else if `count < FIFO_DEPTH`: `req_addr`=`fetch_pc`, →WAIT.
- WAIT, no done: if `i_redirect`: flush, `fetch_pc`=redirect_pc, →DISCARD (address held). Else hold.
- WAIT, done, no redirect: push {`req_addr`, `i_cache_data`}; `fetch_pc`=`req_addr`+4 (mod 2^XLEN). If count_after (count+1−pop) < DEPTH: `req_addr`=`req_addr`+4, stay WAIT (back-to-back); else →IDLE.
- WAIT, done, redirect same cycle: data dropped, flush, `fetch_pc`=`req_addr`=redirect_pc, stay WAIT (new request next cycle).
- DISCARD: done → data dropped, `req_addr`=`fetch_pc`, →WAIT. Redirect in DISCARD updates `fetch_pc` (latest redirect wins), stays DISCARD; redirect+done same cycle → `req_addr`=new redirect_pc, →WAIT.
- FIFO: pop on `o_valid && i_ready`; push+pop same cycle keeps count. Pointers wrap mod DEPTH. No push when full is structurally guaranteed (request issued only with space); assertion on overflow/underflow.
- Flush (any redirect): pointers and count to 0 next edge; simultaneous pop and push discarded. Handshake completing on the redirect cycle is still a transfer from decode's view.
- No head bypass: pushed entry visible at `o_valid` the cycle after the push edge.

## Timing
- Reset release (first edge with `i_reset`=1) moves IDLE→WAIT; `o_cache_valid_address` high the next cycle.
- `i_cache_done` at edge E → `o_valid`, `o_instr`, `o_pc` valid in cycle after E (1-cycle latency).
- Back-to-back: new `o_cache_address` presented the cycle after done; throughput = one instruction per cache latency+0 cycles.
- Redirect at edge E → `o_valid`=0 after E; first redirected instruction appears 1 cycle after its done.
- Outputs `o_instr`/`o_pc` hold stable while `o_valid && !i_ready`.

## Test plan
- Reset, RESET_PC=0x100, cache done 2 cycles after each request, `i_ready`=1 → decode receives pc 0x100,0x104,0x108 with matching words, no gaps other than cache latency.
- `i_ready`=0 throughout, DEPTH=4 → exactly 4 requests (0x0..0xC), `o_cache_valid_address` low after 4th done, head stays pc 0x0; raise `i_ready` → fetch resumes at 0x10.
- Redirect to 0x2003 while WAIT on 0x8 → 0x8 result dropped, next request address 0x2000, first output pc 0x2000.
- Redirect to 0x400 same cycle as done for 0x10 → 0x10 not pushed, FIFO empty next cycle, request 0x400 next cycle.
- `i_reset` low mid-request with done arriving during reset → no push, o_valid 0, restarts at RESET_PC.
- `fetch_pc` 0xFFFF_FFFC → next request 0x0000_0000 (wrap).
